// File: rtl/iter_shift_unit_pkg.sv
// Shared definitions for the iterative shifter: FSM state encoding and
// shift-direction constants.
package iter_shift_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/iter_shift_unit_shift1.sv
// Single-bit shift stage: one position left (zero in) or right (fill_bit in).
module shift1_stage
    import iter_shift_unit_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] data,
    input  logic         dir,
    input  logic         fill_bit,
    output logic [N-1:0] result
);

    always_comb begin
        if (dir == DIR_LEFT) begin
            result = {data[N-2:0], 1'b0};
        end else begin
            result = {fill_bit, data[N-1:1]};
        end
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: applies one single-bit shift per clock until the
// captured amount is exhausted, then pulses done with the result on C.
module iter_shift_unit
    import iter_shift_unit_pkg::*;
#(
    parameter int N   = 8,
    parameter int SHW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [SHW-1:0] SHAMT,
    input  logic           DIR,
    input  logic           ARITH,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   C
);

    // The counter must be able to hold N itself so an over-range amount on a
    // non-power-of-two width can be clamped to a full, all-fill shift.
    localparam int CW = $clog2(N + 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   amt;
    logic            dir_q;
    logic            arith_q;
    logic            accept;
    logic            fill_bit;
    logic [N-1:0]    c_shifted;

    function automatic logic [CW-1:0] clamp_amt(input logic [SHW-1:0] a);
        logic [CW-1:0] w;
        w = CW'(a);
        return (w >= CW'(N)) ? CW'(N) : w;
    endfunction

    assign amt      = clamp_amt(SHAMT);
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign fill_bit = arith_q & C[N-1];

    shift1_stage #(
        .N (N)
    ) u_shift1 (
        .data     (C),
        .dir      (dir_q),
        .fill_bit (fill_bit),
        .result   (c_shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = (amt == '0) ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Result register and remaining-shift counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            C     <= '0;
            count <= '0;
        end else if (accept) begin
            C     <= A;
            count <= amt;
        end else if (state == SHIFT) begin
            C     <= c_shifted;
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dir_q   <= DIR;
            arith_q <= ARITH;
        end
    end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Scenario bench for iter_shift_unit: expected results are queued when an
// operation is issued and popped when done is observed.
module tb_iter_shift_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [2:0] SHAMT;
    logic       DIR;
    logic       ARITH;
    logic       busy;
    logic       done;
    logic [7:0] C;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] a;
        logic [2:0] sh;
        logic       dir;
        logic       ar;
        logic [7:0] expv;
    } op_t;

    iter_shift_unit #(
        .N   (8),
        .SHW (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .SHAMT (SHAMT),
        .DIR   (DIR),
        .ARITH (ARITH),
        .busy  (busy),
        .done  (done),
        .C     (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [2:0] sh, input logic d,
                         input logic ar, input logic [7:0] expv);
        A = a; SHAMT = sh; DIR = d; ARITH = ar; start = 1'b1;
        sb.push_back(expv);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        bit seen;
        rst = 1'b1; start = 1'b1; A = 8'hB5; SHAMT = 3'd2; DIR = 1'b0; ARITH = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (C !== 8'h00) begin n_fail++; $display("FAIL reset_C cycle %0d: got %h want 00", c, C); end
            n_tests++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done cycle %0d: got %b want 0", c, done); end
            n_tests++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cycle %0d: got %b want 0", c, busy); end
        end
        rst = 1'b0;
        sb.push_back(8'hD4);
        @(posedge clk); #1;
        seen = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            n_tests++;
            if (busy !== (c <= 2)) begin n_fail++; $display("FAIL post_reset_busy cycle %0d: got %b want %b", c, busy, (c <= 2)); end
            n_tests++;
            if (done !== (c == 3)) begin n_fail++; $display("FAIL post_reset_done cycle %0d: got %b want %b", c, done, (c == 3)); end
            if (done === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                seen = 1;
                n_tests++;
                if (C !== e) begin n_fail++; $display("FAIL post_reset_C: got %h want %h", C, e); end
            end
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL post_reset_no_done: got none want one done pulse"); end
        @(posedge clk); #1;
    endtask

    task automatic test_shift_ops();
        op_t ops[4];
        logic [7:0] e;
        bit seen;
        ops[0] = '{8'hB5, 3'd3, 1'b0, 1'b0, 8'hA8};
        ops[1] = '{8'hB5, 3'd3, 1'b1, 1'b0, 8'h16};
        ops[2] = '{8'hB5, 3'd3, 1'b1, 1'b1, 8'hF6};
        ops[3] = '{8'hB5, 3'd0, 1'b0, 1'b0, 8'hB5};
        foreach (ops[i]) begin
            issue(ops[i].a, ops[i].sh, ops[i].dir, ops[i].ar, ops[i].expv);
            seen = 0;
            for (int c = 1; c <= 7; c++) begin
                @(negedge clk);
                n_tests++;
                if (busy !== (c <= int'(ops[i].sh))) begin
                    n_fail++;
                    $display("FAIL op%0d_busy cycle %0d: got %b want %b", i, c, busy, (c <= int'(ops[i].sh)));
                end
                n_tests++;
                if (done !== (c == int'(ops[i].sh) + 1)) begin
                    n_fail++;
                    $display("FAIL op%0d_done cycle %0d: got %b want %b", i, c, done, (c == int'(ops[i].sh) + 1));
                end
                if (done === 1'b1 && sb.size() > 0) begin
                    e = sb.pop_front();
                    seen = 1;
                    n_tests++;
                    if (C !== e) begin n_fail++; $display("FAIL op%0d_C: got %h want %h", i, C, e); end
                end else if (seen) begin
                    n_tests++;
                    if (C !== ops[i].expv) begin n_fail++; $display("FAIL op%0d_hold cycle %0d: got %h want %h", i, c, C, ops[i].expv); end
                end
            end
            n_tests++;
            if (!seen) begin n_fail++; $display("FAIL op%0d_no_done: got none want one done pulse", i); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        logic exp_busy;
        logic exp_done;
        int   n_done;
        issue(8'hFF, 3'd7, 1'b0, 1'b0, 8'h80);
        n_done = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            exp_busy = (c <= 7) || (c == 9);
            exp_done = (c == 8) || (c == 10);
            n_tests++;
            if (busy !== exp_busy) begin n_fail++; $display("FAIL b2b_busy cycle %0d: got %b want %b", c, busy, exp_busy); end
            n_tests++;
            if (done !== exp_done) begin n_fail++; $display("FAIL b2b_done cycle %0d: got %b want %b", c, done, exp_done); end
            if (done === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_done++;
                n_tests++;
                if (C !== e) begin n_fail++; $display("FAIL b2b_C cycle %0d: got %h want %h", c, C, e); end
            end
            start = 1'b0;
            if (c == 3) begin
                A = 8'h01; start = 1'b1;
            end
            if (c == 8) begin
                A = 8'h81; SHAMT = 3'd1; DIR = 1'b1; ARITH = 1'b1; start = 1'b1;
                sb.push_back(8'hC0);
            end
        end
        n_tests++;
        if (n_done != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        issue(8'hB5, 3'd5, 1'b0, 1'b0, 8'hA0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            n_tests++;
            if (busy !== (c <= 2)) begin n_fail++; $display("FAIL rmid_busy cycle %0d: got %b want %b", c, busy, (c <= 2)); end
            n_tests++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done cycle %0d: got %b want 0", c, done); end
            if (c == 3) begin
                n_tests++;
                if (C !== 8'h00) begin n_fail++; $display("FAIL rmid_C: got %h want 00", C); end
            end
            rst = (c == 2);
        end
        sb.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; SHAMT = '0; DIR = 1'b0; ARITH = 1'b0;
        test_reset();
        test_shift_ops();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
